pgm_sched: RTL



---
 rtl/pgm_pkg.sv | 22 ++
 rtl/pgm_sched_cfg.sv | 92 +++++++++
 rtl/pgm_sched.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/pgm_pkg.sv
// rtl/pgm_pkg.sv - shared constants and state encoding for the packet-generator scheduler
package pgm_pkg;

    localparam logic [1:0] HDR_FIRST = 2'b01;
    localparam logic [1:0] HDR_MID   = 2'b11;
    localparam logic [1:0] HDR_LAST  = 2'b10;

    localparam logic [7:0] OP_WR = 8'h01;

    localparam logic [15:0] REG_CTRL = 16'd0;
    localparam logic [15:0] REG_LEN  = 16'd1;
    localparam logic [15:0] REG_REP  = 16'd2;
    localparam logic [15:0] REG_GAP  = 16'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_READ = 2'd2,
        ST_GAP  = 2'd3
    } sched_state_e;

endpackage

// File: rtl/pgm_sched_cfg.sv
// rtl/pgm_sched_cfg.sv - config chain pass-through with register decode and start/stop pulses
module pgm_sched_cfg
    import pgm_pkg::*;
#(
    parameter logic [7:0] LMID   = 8'd6,
    parameter int         RAM_AW = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [133:0]      cin_data,
    input  logic              cin_wr,
    input  logic              fsm_idle,
    output logic [133:0]      cout_data,
    output logic              cout_wr,
    output logic [RAM_AW-1:0] pkt_lines,
    output logic [31:0]       rep_num,
    output logic [15:0]       gap_len,
    output logic              start_pulse,
    output logic              stop_pulse
);

    logic [133:0]      cout_data_q, cout_data_d;
    logic              cout_wr_q, cout_wr_d;
    logic              beat1_q, beat1_d;
    logic [RAM_AW-1:0] pkt_lines_q, pkt_lines_d;
    logic [31:0]       rep_num_q, rep_num_d;
    logic [15:0]       gap_len_q, gap_len_d;
    logic              start_q, start_d;
    logic              stop_q, stop_d;

    always_comb begin
        cout_data_d = cin_data;
        cout_wr_d   = cin_wr;
        beat1_d     = beat1_q;
        pkt_lines_d = pkt_lines_q;
        rep_num_d   = rep_num_q;
        gap_len_d   = gap_len_q;
        start_d     = 1'b0;
        stop_d      = 1'b0;
        if (cin_wr) begin
            // The beat right after a first-header beat carries the register command.
            if (beat1_q) begin
                beat1_d = 1'b0;
                if (cin_data[127:120] == LMID && cin_data[119:112] == OP_WR) begin
                    case (cin_data[111:96])
                        REG_CTRL: begin
                            start_d = cin_data[0];
                            stop_d  = cin_data[1] & ~cin_data[0];
                        end
                        REG_LEN: if (fsm_idle) pkt_lines_d = cin_data[RAM_AW-1:0];
                        REG_REP: if (fsm_idle) rep_num_d = cin_data[31:0];
                        REG_GAP: if (fsm_idle) gap_len_d = cin_data[15:0];
                        default: ;
                    endcase
                end
            end else if (cin_data[133:132] == HDR_FIRST) begin
                beat1_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cout_data_q <= '0;
            cout_wr_q   <= 1'b0;
            beat1_q     <= 1'b0;
            pkt_lines_q <= RAM_AW'(1);
            rep_num_q   <= 32'd1;
            gap_len_q   <= 16'd0;
            start_q     <= 1'b0;
            stop_q      <= 1'b0;
        end else begin
            cout_data_q <= cout_data_d;
            cout_wr_q   <= cout_wr_d;
            beat1_q     <= beat1_d;
            pkt_lines_q <= pkt_lines_d;
            rep_num_q   <= rep_num_d;
            gap_len_q   <= gap_len_d;
            start_q     <= start_d;
            stop_q      <= stop_d;
        end
    end

    assign cout_data   = cout_data_q;
    assign cout_wr     = cout_wr_q;
    assign pkt_lines   = pkt_lines_q;
    assign rep_num     = rep_num_q;
    assign gap_len     = gap_len_q;
    assign start_pulse = start_q;
    assign stop_pulse  = stop_q;

endmodule

// File: rtl/pgm_sched.sv
// rtl/pgm_sched.sv - replay scheduler: sequences RAM reads to emit the stored packet N times
module pgm_sched
    import pgm_pkg::*;
#(
    parameter logic [7:0] LMID   = 8'd6,
    parameter int         RAM_AW = 7,
    parameter int         RAM_DW = 144
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [133:0]      cin_sched_data,
    input  logic              cin_sched_data_wr,
    output logic              cout_sched_ready,
    output logic [133:0]      cout_sched_data,
    output logic              cout_sched_data_wr,
    input  logic              cin_sched_ready,
    output logic [RAM_AW-1:0] sched2ram_addr,
    output logic              sched2ram_rd,
    input  logic [RAM_DW-1:0] ram2sched_rdata,
    output logic [133:0]      out_sched_data,
    output logic              out_sched_data_wr,
    output logic              out_sched_valid,
    output logic              out_sched_valid_wr,
    input  logic              in_sched_alf,
    output logic              out_sched_sent_start_flag,
    output logic              out_sched_sent_finish_flag
);

    logic [RAM_AW-1:0] pkt_lines;
    logic [31:0]       rep_num;
    logic [15:0]       gap_len;
    logic              start_pulse;
    logic              stop_pulse;

    sched_state_e      state_q, state_d;
    logic [RAM_AW-1:0] addr_q, addr_d;
    logic [31:0]       pkt_cnt_q, pkt_cnt_d;
    logic [15:0]       gap_cnt_q, gap_cnt_d;
    logic              stop_lat_q, stop_lat_d;
    logic              start_flag_q, start_flag_d;
    logic              run_end_q, run_end_d;
    logic              finish_q, finish_d;
    logic              out_wr_q, out_wr_d;
    logic              out_last_q, out_last_d;
    logic [1:0]        out_hdr_q, out_hdr_d;
    logic              valid_q, valid_d;
    logic              rd;
    logic              run_done;

    pgm_sched_cfg #(
        .LMID   (LMID),
        .RAM_AW (RAM_AW)
    ) u_cfg (
        .clk         (clk),
        .rst_n       (rst_n),
        .cin_data    (cin_sched_data),
        .cin_wr      (cin_sched_data_wr),
        .fsm_idle    (state_q == ST_IDLE),
        .cout_data   (cout_sched_data),
        .cout_wr     (cout_sched_data_wr),
        .pkt_lines   (pkt_lines),
        .rep_num     (rep_num),
        .gap_len     (gap_len),
        .start_pulse (start_pulse),
        .stop_pulse  (stop_pulse)
    );

    assign run_done = ((rep_num != 32'd0) && (pkt_cnt_q + 32'd1 == rep_num)) || stop_lat_q;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        pkt_cnt_d    = pkt_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        stop_lat_d   = stop_lat_q;
        start_flag_d = start_flag_q;
        run_end_d    = 1'b0;
        finish_d     = run_end_q;
        out_wr_d     = 1'b0;
        out_last_d   = 1'b0;
        out_hdr_d    = 2'b00;
        valid_d      = 1'b1;
        rd           = 1'b0;

        // Flags change one cycle late so the finish pulse trails the final valid_wr.
        if (run_end_q) start_flag_d = 1'b0;
        if (stop_pulse && state_q != ST_IDLE) stop_lat_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (start_pulse) begin
                    pkt_cnt_d    = 32'd0;
                    stop_lat_d   = 1'b0;
                    start_flag_d = 1'b1;
                    state_d      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (stop_lat_q) begin
                    stop_lat_d = 1'b0;
                    run_end_d  = 1'b1;
                    state_d    = ST_IDLE;
                end else if (!in_sched_alf) begin
                    addr_d  = '0;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                rd       = 1'b1;
                out_wr_d = 1'b1;
                if (addr_q == '0)             out_hdr_d = HDR_FIRST;
                else if (addr_q == pkt_lines) out_hdr_d = HDR_LAST;
                else                          out_hdr_d = HDR_MID;
                if (addr_q == pkt_lines) begin
                    out_last_d = 1'b1;
                    pkt_cnt_d  = pkt_cnt_q + 32'd1;
                    if (run_done) begin
                        stop_lat_d = 1'b0;
                        run_end_d  = 1'b1;
                        state_d    = ST_IDLE;
                    end else if (gap_len > 16'd1) begin
                        // WAIT itself is one idle cycle, so GAP covers the remaining gap-1.
                        gap_cnt_d = 16'd1;
                        state_d   = ST_GAP;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    addr_d = addr_q + RAM_AW'(1);
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == gap_len - 16'd1) state_d = ST_WAIT;
                else                              gap_cnt_d = gap_cnt_q + 16'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            pkt_cnt_q    <= 32'd0;
            gap_cnt_q    <= 16'd0;
            stop_lat_q   <= 1'b0;
            start_flag_q <= 1'b0;
            run_end_q    <= 1'b0;
            finish_q     <= 1'b0;
            out_wr_q     <= 1'b0;
            out_last_q   <= 1'b0;
            out_hdr_q    <= 2'b00;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            pkt_cnt_q    <= pkt_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            stop_lat_q   <= stop_lat_d;
            start_flag_q <= start_flag_d;
            run_end_q    <= run_end_d;
            finish_q     <= finish_d;
            out_wr_q     <= out_wr_d;
            out_last_q   <= out_last_d;
            out_hdr_q    <= out_hdr_d;
            valid_q      <= valid_d;
        end
    end

    logic unused_rdata;
    assign unused_rdata = ^{ram2sched_rdata[RAM_DW-1:134], ram2sched_rdata[133:132]};

    assign cout_sched_ready           = cin_sched_ready;
    assign sched2ram_addr             = addr_q;
    assign sched2ram_rd               = rd;
    assign out_sched_data             = out_wr_q ? {out_hdr_q, ram2sched_rdata[131:0]} : 134'd0;
    assign out_sched_data_wr          = out_wr_q;
    assign out_sched_valid            = valid_q;
    assign out_sched_valid_wr         = out_last_q;
    assign out_sched_sent_start_flag  = start_flag_q;
    assign out_sched_sent_finish_flag = finish_q;

endmodule
